// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and memory sizing defaults.
package imem_loader_pkg;

    localparam int ROM_WORDS_DEF  = 1024;
    localparam int AW_DEF         = 10;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four bytes MSB-first into a 32-bit word; full_o flags the byte that completes a word.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // The counter wraps to 0 after the fourth byte, so the next word starts cleanly.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (shift_i) begin
            data_d = {data_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    assign word_o = data_q;
    assign full_o = shift_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory, holding the CPU off while it owns the port.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEF,
    parameter int AW        = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW:0]   word_count,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          fetch_stall,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state_o
);

    localparam logic [AW:0] MAX_WC = (AW+1)'(ROM_WORDS);

    // Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   wc_q, wc_d;
    logic          err_q, err_d;

    logic          accept;
    logic          wc_ok;
    logic          asm_clr;
    logic          asm_full;
    logic [31:0]   asm_word;
    logic [AW:0]   idx_plus1;
    logic          last_word;

    assign accept    = byte_valid && byte_ready;
    assign wc_ok     = (word_count != '0) && (word_count <= MAX_WC);
    assign idx_plus1 = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
    assign last_word = (idx_plus1 == wc_q);

    word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (asm_clr),
        .shift_i (accept),
        .byte_i  (byte_data),
        .word_o  (asm_word),
        .full_o  (asm_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (load_start && wc_ok) state_d = ST_COLLECT;
            ST_COLLECT: if (asm_full)            state_d = ST_WRITE;
            ST_WRITE:   state_d = last_word ? ST_DONE : ST_COLLECT;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            wc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            wc_q  <= wc_d;
            err_q <= err_d;
        end
    end

    // The index stops at the final word, so a full-depth load never wraps to 0.
    always_comb begin
        idx_d   = idx_q;
        wc_d    = wc_q;
        err_d   = 1'b0;
        asm_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (wc_ok) begin
                        idx_d   = '0;
                        wc_d    = word_count;
                        asm_clr = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (!last_word) idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    always_comb begin
        byte_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = asm_word;
                busy      = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        fetch_stall = busy;
        err         = err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 10, meaning word-address width, clog2(ROM_WORDS).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port word_count  input  AW+1  number of words to load, sampled with load_start.
REQ-007 SHALL have port byte_valid  input  1  source presents byte_data.
REQ-008 SHALL have port byte_data  input  8  program byte, big-endian within a word.
REQ-009 SHALL have port byte_ready  output  1  loader accepts the byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port mem_waddr  output  AW  word address of the write.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port fetch_stall  output  1  CPU shall hold its PC; memory is owned by the loader.
REQ-014 SHALL have port busy  output  1  a load is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the load completes.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected load_start.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: load_start with 1 <= word_count <= ROM_WORDS SHALL go to COLLECT, clearing the byte counter and word index.
REQ-019 IDLE: load_start with word_count 0 or > ROM_WORDS SHALL pulse err the next cycle and stay in IDLE.
REQ-020 byte_ready SHALL be high only in COLLECT; a byte is accepted when byte_valid && byte_ready.
REQ-021 Accepted bytes SHALL shift in MSB-first: the first byte lands in [31:24], the fourth in [7:0].
REQ-022 On the 4th accepted byte, the next state SHALL be WRITE.
REQ-023 WRITE SHALL last exactly 1 cycle: mem_we=1, mem_waddr=word index, mem_wdata=assembled word.
REQ-024 After WRITE, the word index SHALL increment; the FSM SHALL go to DONE if index+1 == word_count, else to COLLECT.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 Latency: with the last byte accepted in cycle N, mem_we SHALL be high in N+1 and done in N+2.
REQ-027 busy and fetch_stall SHALL be 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-028 load_start outside IDLE SHALL be ignored (no err, no restart).
REQ-029 A byte_valid gap SHALL stall COLLECT indefinitely without losing the partial word.
REQ-030 mem_waddr SHALL never exceed ROM_WORDS-1; the index does not wrap within one load.
REQ-031 mem_we SHALL be 0 in every state other than WRITE.

Reset
REQ-032 rst SHALL force IDLE, byte counter 0, word index 0, and data register 0.
REQ-033 Reset values SHALL be: byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, fetch_stall=0, busy=0, done=0, err=0.
REQ-034 rst during a load SHALL abort it with no done pulse; already-written words remain in memory.
REQ-035 rst SHALL take priority over load_start and byte acceptance in the same cycle.

Structure
REQ-036 FSM state encoding and the ROM_WORDS/AW defaults SHALL live in the shared mem package.
REQ-037 The 4-byte shift/assembly register with its 2-bit counter SHALL be a sub-module named word_assembler.
REQ-038 Memory-port muxing (loader write vs CPU fetch) SHALL stay outside this block; fetch_stall is the only coupling.

Verification
REQ-039 load_start, word_count=2, bytes 3C 08 10 01 20 09 00 05 streamed every cycle -> mem_we at addr 0 data 3C081001, then addr 1 data 20090005; done 2 cycles after the last byte.
REQ-040 word_count=0 and separately word_count=1025 -> err pulses once, busy stays 0, no mem_we.
REQ-041 word_count=1 with 3-cycle byte_valid gaps between bytes -> single write of the correct word; byte_ready stays high throughout COLLECT.
REQ-042 rst asserted after 5 accepted bytes of a 2-word load -> immediate IDLE, no done; a new load afterwards writes from addr 0.
REQ-043 load_start pulsed mid-load -> ignored; the original load completes with the original word_count.
REQ-044 word_count=1024 full load -> final write at addr 1023; fetch_stall high from the cycle after load_start through DONE.
